// File: rtl/sdram_pkg.sv
// sdram_pkg - definitions shared by the SDRAM controller blocks
// (arbiter, init, auto-refresh, read and write stages).
//   sdram_cmd_t     : 4-bit command {CS_n, RAS_n, CAS_n, WE_n}
//   CMD_*           : command encodings
//   *_DEF           : default timing constants in clock cycles (100 MHz)
//   *_state_t       : FSM state encodings, one per controller block
//   max2()          : helper for sizing counters that serve two delays
package sdram_pkg;

  typedef logic [3:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP       = 4'b0111;
  localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;
  localparam sdram_cmd_t CMD_AREF      = 4'b0001;
  localparam sdram_cmd_t CMD_ACTIVE    = 4'b0011;
  localparam sdram_cmd_t CMD_READ      = 4'b0101;
  localparam sdram_cmd_t CMD_WRITE     = 4'b0100;
  localparam sdram_cmd_t CMD_MRS       = 4'b0000;

  localparam int TRP_DEF          = 2;
  localparam int TRC_DEF          = 7;
  localparam int REF_INTERVAL_DEF = 750;
  localparam int AREF_NUM_DEF     = 2;

  typedef enum logic [2:0] {
    ARB_IDLE, ARB_ARBIT, ARB_AREF, ARB_WRITE, ARB_READ
  } arbit_state_t;

  typedef enum logic [2:0] {
    INIT_WAIT, INIT_PRE, INIT_TRP, INIT_AREF, INIT_TRC, INIT_MRS, INIT_TMRD, INIT_END
  } init_state_t;

  typedef enum logic [2:0] {
    AREF_S_IDLE, AREF_S_PRE, AREF_S_WAIT_RP, AREF_S_AREF, AREF_S_WAIT_RC, AREF_S_END
  } aref_state_t;

  typedef enum logic [2:0] {
    RD_IDLE, RD_ACT, RD_TRCD, RD_CMD, RD_CL, RD_DATA, RD_PRE, RD_END
  } rd_state_t;

  typedef enum logic [2:0] {
    WR_IDLE, WR_ACT, WR_TRCD, WR_CMD, WR_DATA, WR_TWR, WR_PRE, WR_END
  } wr_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_aref_if.sv
// sdram_aref_if - signals between the auto-refresh stage and its
// neighbours (init block, arbiter, SDRAM command mux).
//   flag_init_end : init done (pulse or level)
//   ref_en        : refresh grant from arbiter (level)
//   ref_req       : refresh request to arbiter
//   flag_ref_end  : one-cycle pulse, refresh sequence complete
//   aref_cmd      : {CS_n, RAS_n, CAS_n, WE_n}
//   aref_ba       : bank address
//   aref_addr     : address bus (A10=1 on PRECHARGE-all)
// Request/grant: ref_req is a level held until the grant is taken; a grant is
// taken on the edge where ref_en=1 and ref_req=1 are both seen in IDLE.
// ref_en without a pending ref_req is ignored. The sequence then runs to
// completion regardless of ref_en and ends with a single flag_ref_end cycle.
interface sdram_aref_if;
  import sdram_pkg::*;

  logic        flag_init_end;
  logic        ref_en;
  logic        ref_req;
  logic        flag_ref_end;
  sdram_cmd_t  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;

  modport master (
    output flag_init_end, ref_en,
    input  ref_req, flag_ref_end, aref_cmd, aref_ba, aref_addr
  );

  modport slave (
    input  flag_init_end, ref_en,
    output ref_req, flag_ref_end, aref_cmd, aref_ba, aref_addr
  );

endinterface

// File: rtl/sdram_aref.sv
// sdram_aref - SDRAM auto-refresh stage.
// After init completes, a free-running interval timer raises ref_req every
// REF_INTERVAL clocks. On grant, issues PRECHARGE-all, waits TRP, then issues
// AREF_NUM AUTO REFRESH commands spaced TRC apart, waits TRC after the last
// one and pulses flag_ref_end.
//   clk     : system clock
//   rstn    : synchronous active-low reset
//   aref    : sdram_aref_if slave modport (see interface header)
//   o_state : current sequence FSM state (debug)
module sdram_aref
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int TRP          = TRP_DEF,
  parameter int TRC          = TRC_DEF,
  parameter int AREF_NUM     = AREF_NUM_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  sdram_aref_if.slave aref,
  output aref_state_t o_state
);

  if (AREF_NUM < 1 || TRP < 1 || TRC < 1) begin : g_param_check
    $error("sdram_aref: AREF_NUM, TRP and TRC must all be >= 1");
  end

  localparam int INT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int CYC_W = $clog2(max2(TRP, TRC)) + 1;
  localparam int NUM_W = $clog2(AREF_NUM + 1);

  localparam logic [INT_W-1:0] INT_MAX = INT_W'(REF_INTERVAL - 1);
  localparam logic [CYC_W-1:0] RP_LAST = CYC_W'(TRP - 1);
  localparam logic [CYC_W-1:0] RC_LAST = CYC_W'(TRC - 1);
  localparam logic [NUM_W-1:0] NUM_MAX = NUM_W'(AREF_NUM);

  logic              r_init_done;
  logic [INT_W-1:0]  r_int;
  logic              r_ref_req;
  aref_state_t       r_state;
  aref_state_t       w_next;
  logic [CYC_W-1:0]  r_cyc;
  logic [NUM_W-1:0]  r_aref_cnt;
  sdram_cmd_t        r_cmd;
  logic [12:0]       r_addr;
  logic              r_flag;

  logic              w_wrap;
  logic              w_leave_idle;
  sdram_cmd_t        w_cmd;
  logic [12:0]       w_addr;

  assign w_wrap       = r_init_done && (r_int == INT_MAX);
  assign w_leave_idle = (r_state == AREF_S_IDLE) && (w_next != AREF_S_IDLE);

  // Next-state logic. r_cyc is 0 in the PRE/AREF cycle itself, so the wait
  // ends when it reaches delay-1. r_aref_cnt already includes the AREF just
  // issued once we are in WAIT_RC.
  always_comb begin
    w_next = r_state;
    case (r_state)
      AREF_S_IDLE:    if (aref.ref_en && r_ref_req) w_next = AREF_S_PRE;
      AREF_S_PRE:     w_next = (TRP == 1) ? AREF_S_AREF : AREF_S_WAIT_RP;
      AREF_S_WAIT_RP: if (r_cyc == RP_LAST) w_next = AREF_S_AREF;
      AREF_S_AREF: begin
        if (TRC > 1)
          w_next = AREF_S_WAIT_RC;
        else if (NUM_W'(r_aref_cnt + NUM_W'(1)) < NUM_MAX)
          w_next = AREF_S_AREF;
        else
          w_next = AREF_S_END;
      end
      AREF_S_WAIT_RC: begin
        if (r_cyc == RC_LAST)
          w_next = (r_aref_cnt < NUM_MAX) ? AREF_S_AREF : AREF_S_END;
      end
      AREF_S_END:     w_next = AREF_S_IDLE;
      default:        w_next = AREF_S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the command
  // appears in the same cycle the FSM sits in the corresponding state.
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    case (w_next)
      AREF_S_PRE: begin
        w_cmd      = CMD_PRECHARGE;
        w_addr[10] = 1'b1;
      end
      AREF_S_AREF: w_cmd = CMD_AREF;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_init_done <= 1'b0;
      r_int       <= '0;
      r_ref_req   <= 1'b0;
      r_state     <= AREF_S_IDLE;
      r_cyc       <= '0;
      r_aref_cnt  <= '0;
      r_cmd       <= CMD_NOP;
      r_addr      <= '0;
      r_flag      <= 1'b0;
    end else begin
      r_init_done <= r_init_done | aref.flag_init_end;

      // Free-running after init; a refresh never restarts the interval.
      if (!r_init_done || w_wrap)
        r_int <= '0;
      else
        r_int <= r_int + INT_W'(1);

      // Set has priority so a wrap on the grant edge is not lost.
      if (w_wrap)
        r_ref_req <= 1'b1;
      else if (w_leave_idle)
        r_ref_req <= 1'b0;

      r_state <= w_next;

      if (w_next == AREF_S_PRE || w_next == AREF_S_AREF)
        r_cyc <= '0;
      else if (r_cyc != '1)
        r_cyc <= r_cyc + CYC_W'(1);

      if (r_state == AREF_S_IDLE)
        r_aref_cnt <= '0;
      else if (r_state == AREF_S_AREF)
        r_aref_cnt <= r_aref_cnt + NUM_W'(1);

      r_cmd  <= w_cmd;
      r_addr <= w_addr;
      r_flag <= (w_next == AREF_S_END);
    end
  end

  assign aref.ref_req      = r_ref_req;
  assign aref.flag_ref_end = r_flag;
  assign aref.aref_cmd     = r_cmd;
  assign aref.aref_ba      = 2'b00;
  assign aref.aref_addr    = r_addr;
  assign o_state           = r_state;

endmodule
